// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: NOP encoding, major opcodes, fetch-stage state and buffer entry.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between memory return and decoder; flush empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the valid window is defined by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, single-outstanding imem request FSM, redirect handling, decoder buffer.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruccion,
  output logic [31:0] pc_out
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic [31:0]  pc_last;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  logic space_c;
  logic grant_c;
  logic push_c;
  logic pop_c;

  // Space is judged after this cycle's pop so a draining buffer keeps fetching.
  assign pop_c    = !fifo_empty && instr_ready;
  assign space_c  = (fifo_count - CW'(pop_c)) < CW'(FIFO_DEPTH);
  assign imem_req = !rst && (state == F_REQ) && space_c;
  assign imem_addr = pc;
  assign grant_c  = imem_req && imem_gnt;

  assign push_c = !rst && !redirect && (state == F_WAIT) && imem_rvalid
                  && (!fifo_full || pop_c);
  assign push_entry = '{pc: req_pc, instr: imem_rdata};

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .din   (push_entry),
    .pop   (pop_c),
    .flush (redirect),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign instr_valid = !fifo_empty;
  assign instruccion = fifo_empty ? NOP_INSTR : head.instr;
  assign pc_out      = fifo_empty ? pc_last : head.pc;

  // PC and fetch FSM; a redirect overrides normal sequencing and drops any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= F_REQ;
      pc      <= RESET_PC;
      req_pc  <= RESET_PC;
      pc_last <= '0;
    end else begin
      if (!fifo_empty) pc_last <= head.pc;
      if (redirect) begin
        pc <= word_align(redirect_pc);
        case (state)
          F_REQ:   state <= grant_c ? F_DROP : F_REQ;
          F_WAIT:  state <= imem_rvalid ? F_REQ : F_DROP;
          F_DROP:  state <= imem_rvalid ? F_REQ : F_DROP;
          default: state <= F_REQ;
        endcase
      end else begin
        case (state)
          F_REQ: begin
            if (grant_c) begin
              state  <= F_WAIT;
              req_pc <= pc;
              pc     <= pc + 32'd4;
            end
          end
          F_WAIT:  if (imem_rvalid) state <= F_REQ;
          F_DROP:  if (imem_rvalid) state <= F_REQ;
          default: state <= F_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs driven on the falling edge, outputs checked 1 time unit later.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruccion;
  logic [31:0] pc_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruccion (instruccion),
    .pc_out      (pc_out)
  );

  // Instruction memory contents: recognisable word tagged with its own address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic rdr, input logic [31:0] rpc, input logic rs);
    @(negedge clk);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    instr_ready = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    rst         = rs;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    instr_ready = 1; redirect = 0; redirect_pc = 0;

    // Reset state and sequential fetch with a 1-cycle memory
    do_reset();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instruccion, NOP);
    chk("rst_pc_out", pc_out, 0);

    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t1_req0", 32'(imem_req), 1);
    chk("t1_addr0", imem_addr, 32'h0);
    drive(0, 1, memw(32'h0), 1, 0, 0, 0);
    chk("t1_wait_req", 32'(imem_req), 0);
    chk("t1_no_bypass", 32'(instr_valid), 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t1_valid0", 32'(instr_valid), 1);
    chk("t1_instr0", instruccion, memw(32'h0));
    chk("t1_pc0", pc_out, 32'h0);
    chk("t1_req4", 32'(imem_req), 1);
    chk("t1_addr4", imem_addr, 32'h4);
    drive(0, 1, memw(32'h4), 1, 0, 0, 0);
    chk("t1_gap_valid", 32'(instr_valid), 0);
    chk("t1_gap_instr", instruccion, NOP);
    chk("t1_gap_pc_hold", pc_out, 32'h0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t1_instr4", instruccion, memw(32'h4));
    chk("t1_pc4", pc_out, 32'h4);
    chk("t1_addr8", imem_addr, 32'h8);

    // Decoder stall: buffer fills to depth, requests stop, then drain in order
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, memw(32'h0), 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t2_req_with_space", 32'(imem_req), 1);
    drive(0, 1, memw(32'h4), 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t2_full_req", 32'(imem_req), 0);
      chk("t2_full_head", instruccion, memw(32'h0));
    end
    chk("t2_full_pc_held", imem_addr, 32'h8);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t2_drain_pc0", pc_out, 32'h0);
    chk("t2_resume_req", 32'(imem_req), 1);
    chk("t2_resume_addr", imem_addr, 32'h8);
    drive(0, 1, memw(32'h8), 1, 0, 0, 0);
    chk("t2_drain_pc4", pc_out, 32'h4);
    chk("t2_drain_instr4", instruccion, memw(32'h4));
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t2_drain_pc8", pc_out, 32'h8);
    chk("t2_drain_instr8", instruccion, memw(32'h8));
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t2_empty", 32'(instr_valid), 0);

    // Redirect while waiting: buffer flushed, in-flight word dropped, fetch at aligned target
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, memw(32'h0), 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h0000_0102, 0);
    chk("t3_valid_before", 32'(instr_valid), 1);
    drive(0, 1, memw(32'h4), 1, 0, 0, 0);
    chk("t3_flushed", 32'(instr_valid), 0);
    chk("t3_drop_req", 32'(imem_req), 0);
    chk("t3_pc_out_hold", pc_out, 32'h0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t3_dropped", 32'(instr_valid), 0);
    chk("t3_req_new", 32'(imem_req), 1);
    chk("t3_addr_new", imem_addr, 32'h0000_0100);
    drive(0, 1, memw(32'h100), 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t3_valid_new", 32'(instr_valid), 1);
    chk("t3_pc_new", pc_out, 32'h0000_0100);
    chk("t3_instr_new", instruccion, memw(32'h100));

    // Redirect in the same cycle as a grant: the granted word is discarded
    do_reset();
    drive(1, 0, 0, 1, 1, 32'h0000_0200, 0);
    chk("t4_req", 32'(imem_req), 1);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t4_drop_req", 32'(imem_req), 0);
    drive(0, 1, memw(32'h0), 1, 0, 0, 0);
    chk("t4_drop_req2", 32'(imem_req), 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t4_discarded", 32'(instr_valid), 0);
    chk("t4_addr_new", imem_addr, 32'h0000_0200);
    drive(0, 1, memw(32'h200), 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t4_pc_new", pc_out, 32'h0000_0200);
    chk("t4_instr_new", instruccion, memw(32'h200));

    // Grant delayed three cycles: address held, exactly one word buffered
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t5_req_held", 32'(imem_req), 1);
      chk("t5_addr_held", imem_addr, 32'h0);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t5_addr_at_gnt", imem_addr, 32'h0);
    drive(0, 1, memw(32'h0), 0, 0, 0, 0);
    chk("t5_no_bypass", 32'(instr_valid), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t5_valid", 32'(instr_valid), 1);
    chk("t5_instr", instruccion, memw(32'h0));
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t5_pc", pc_out, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t5_single_push", 32'(instr_valid), 0);

    // Reset during an outstanding request: late responses ignored, restart at RESET_PC
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(0, 1, memw(32'h0), 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(0, 1, memw(32'h4), 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t6_pre_pc", pc_out, 32'h4);
    chk("t6_pre_addr", imem_addr, 32'h8);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, memw(32'h8), 0, 0, 0, 1);
    chk("t6_rst_req", 32'(imem_req), 0);
    chk("t6_rst_valid", 32'(instr_valid), 0);
    chk("t6_rst_instr", instruccion, NOP);
    chk("t6_rst_pc_out", pc_out, 32'h0);
    drive(0, 1, memw(32'h8), 1, 0, 0, 0);
    chk("t6_restart_req", 32'(imem_req), 1);
    chk("t6_restart_addr", imem_addr, 32'h0);
    chk("t6_late_valid", 32'(instr_valid), 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t6_late_ignored", 32'(instr_valid), 0);
    chk("t6_addr0", imem_addr, 32'h0);
    drive(0, 1, memw(32'h0), 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t6_valid", 32'(instr_valid), 1);
    chk("t6_pc", pc_out, 32'h0);
    chk("t6_instr", instruccion, memw(32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
